// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared constants, default geometry table and FSM states for ball_frame_sync
package ball_pkg;

  localparam int NUM_BALLS     = 10;
  localparam int REGS_PER_BALL = 3;
  localparam int NUM_REGS      = NUM_BALLS * REGS_PER_BALL;

  localparam logic [4:0] ADDR_COMMIT = 5'h1E;
  localparam logic [4:0] ADDR_STATUS = 5'h1F;

  // Word order per ball: x, y, size
  localparam logic [15:0] DEFAULT_REGS [NUM_REGS] = '{
    16'd100, 16'd50,  16'd10,
    16'd200, 16'd100, 16'd12,
    16'd300, 16'd150, 16'd8,
    16'd400, 16'd200, 16'd14,
    16'd500, 16'd250, 16'd6,
    16'd600, 16'd300, 16'd16,
    16'd700, 16'd350, 16'd9,
    16'd800, 16'd400, 16'd11,
    16'd150, 16'd75,  16'd13,
    16'd250, 16'd125, 16'd7
  };

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COPY,
    DONE
  } state_t;

  function automatic logic [15:0] default_word(input int i);
    return (i >= 0 && i < NUM_REGS) ? DEFAULT_REGS[i] : 16'd0;
  endfunction

endpackage

// File: rtl/ball_frame_sync_if.sv
// rtl/ball_frame_sync_if.sv - Avalon-style register port between software and ball_frame_sync
interface ball_frame_sync_if #(
  parameter int DW = 16
);
  logic          chipselect;
  logic          write;
  logic          read;
  logic [4:0]    address;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );
endinterface

// File: rtl/ball_reg_bank.sv
// rtl/ball_reg_bank.sv - register array with one write port, one combinational read port and a flat view
module ball_reg_bank
  import ball_pkg::*;
#(
  parameter int  DW = 16,
  parameter int  N  = NUM_REGS,
  localparam int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            load_default,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata,
  output logic [N*DW-1:0] flat
);

  logic [DW-1:0] regs [N];

  always_ff @(posedge clk) begin
    if (load_default) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= DW'(default_word(i));
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

  always_comb begin
    flat = '0;
    for (int i = 0; i < N; i++) begin
      flat[i*DW +: DW] = regs[i];
    end
  end

endmodule

// File: rtl/ball_frame_sync.sv
// rtl/ball_frame_sync.sv - double-buffered ball geometry registers, committed to the renderer at vblank start
module ball_frame_sync
  import ball_pkg::*;
#(
  parameter int DW      = 16,
  parameter int VACTIVE = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  ball_frame_sync_if.slave       avalon,
  input  logic [10:0]            hcount,
  input  logic [9:0]             vcount,
  output logic [NUM_REGS*DW-1:0] ball_regs,
  output logic                   commit_done,
  output logic [15:0]            frame_count
);

  state_t                 state, state_next;
  logic [4:0]             idx, idx_next;
  logic                   commit_req, commit_req_next;
  logic                   wr, rd, pend_we, commit_wr, copy_we, vb_start, busy;
  logic [DW-1:0]          pend_rdata, copy_data, status;
  logic [DW-1:0]          unused_active_rdata;
  logic [NUM_REGS*DW-1:0] pend_flat;

  assign wr        = avalon.chipselect && avalon.write;
  assign rd        = avalon.chipselect && avalon.read;
  assign pend_we   = wr && (avalon.address < 5'(NUM_REGS));
  assign commit_wr = wr && (avalon.address == ADDR_COMMIT);
  assign vb_start  = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
  assign busy      = (state != IDLE);
  assign copy_data = pend_flat[idx*DW +: DW];

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    commit_req_next = commit_req;
    copy_we         = 1'b0;
    commit_done     = 1'b0;
    case (state)
      IDLE: begin
        if (commit_req) begin
          state_next      = ARMED;
          commit_req_next = 1'b0;
        end
      end
      ARMED: begin
        if (vb_start) begin
          state_next = COPY;
          idx_next   = '0;
        end
      end
      COPY: begin
        copy_we  = 1'b1;
        idx_next = idx + 5'd1;
        if (idx == 5'(NUM_REGS - 1)) state_next = DONE;
      end
      DONE: begin
        commit_done = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // An ARMED commit already covers the request; one arriving while arming is absorbed too
    if (commit_wr && (state == COPY || state == DONE || (state == IDLE && !commit_req)))
      commit_req_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      commit_req  <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      commit_req <= commit_req_next;
      if (vb_start) frame_count <= frame_count + 16'd1;
    end
  end

  always_comb begin
    status       = '0;
    status[0]    = busy;
    status[1]    = commit_req;
    status[15:8] = frame_count[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avalon.readdata <= '0;
    end else if (rd) begin
      if (avalon.address < 5'(NUM_REGS))      avalon.readdata <= pend_rdata;
      else if (avalon.address == ADDR_STATUS) avalon.readdata <= status;
      else                                    avalon.readdata <= '0;
    end
  end

  ball_reg_bank #(.DW(DW), .N(NUM_REGS)) pending (
    .clk          (clk),
    .load_default (reset),
    .we           (pend_we),
    .waddr        (avalon.address),
    .wdata        (avalon.writedata),
    .raddr        (avalon.address),
    .rdata        (pend_rdata),
    .flat         (pend_flat)
  );

  // Copy reads pending before this edge's software write, so a same-index write lands next commit
  ball_reg_bank #(.DW(DW), .N(NUM_REGS)) active (
    .clk          (clk),
    .load_default (reset),
    .we           (copy_we),
    .waddr        (idx),
    .wdata        (copy_data),
    .raddr        (idx),
    .rdata        (unused_active_rdata),
    .flat         (ball_regs)
  );

endmodule

// File: tb/tb_ball_frame_sync.sv
// tb/tb_ball_frame_sync.sv - table, corner-case and randomized checks of ball_frame_sync against a timing model
module tb_ball_frame_sync;

  localparam int NR      = 30;
  localparam int H_TOTAL = 40;
  localparam int V_TOTAL = 12;
  localparam int VACT    = 8;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic [NR*16-1:0] ball_regs;
  logic             commit_done;
  logic [15:0]      frame_count;
  bit               video_on;

  ball_frame_sync_if #(.DW(16)) bus ();

  ball_frame_sync #(.DW(16), .VACTIVE(VACT)) dut (
    .clk         (clk),
    .reset       (reset),
    .avalon      (bus),
    .hcount      (hcount),
    .vcount      (vcount),
    .ball_regs   (ball_regs),
    .commit_done (commit_done),
    .frame_count (frame_count)
  );

  always #10 clk = ~clk;

  logic [15:0] dflt [NR] = '{
    16'd100, 16'd50,  16'd10,  16'd200, 16'd100, 16'd12,
    16'd300, 16'd150, 16'd8,   16'd400, 16'd200, 16'd14,
    16'd500, 16'd250, 16'd6,   16'd600, 16'd300, 16'd16,
    16'd700, 16'd350, 16'd9,   16'd800, 16'd400, 16'd11,
    16'd150, 16'd75,  16'd13,  16'd250, 16'd125, 16'd7
  };

  // Reference model: copy timing expressed as the edge at which the copy started
  logic [15:0] m_pend [NR];
  logic [15:0] m_act  [NR];
  bit          m_req, m_armed;
  int          m_copy_e;
  logic [15:0] m_fc, m_rd;
  int          cyc, last_vb, cd_count;
  int          checks, errors;

  typedef struct {
    bit          w;
    bit          r;
    logic [4:0]  a;
    logic [15:0] d;
    logic [15:0] rd;
  } vec_t;
  vec_t vecs [14];

  function automatic logic [15:0] word(input int k);
    return ball_regs[k*16 +: 16];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int j;
    bit busy, was_armed, vb;
    cyc++;
    vb = (hcount == 11'd0) && (vcount == 10'(VACT));
    if (vb) last_vb = cyc;
    if (reset) begin
      for (int k = 0; k < NR; k++) begin
        m_pend[k] = dflt[k];
        m_act[k]  = dflt[k];
      end
      m_req = 0; m_armed = 0; m_copy_e = -100000; m_fc = 16'd0; m_rd = 16'd0;
      return;
    end
    j         = cyc - 1 - m_copy_e;
    busy      = m_armed || (j >= 0 && j <= 30);
    was_armed = m_armed;
    if (bus.chipselect && bus.read) begin
      if (bus.address < 5'd30)       m_rd = m_pend[bus.address];
      else if (bus.address == 5'd31) m_rd = {m_fc[7:0], 6'd0, m_req, busy};
      else                           m_rd = 16'd0;
    end
    if (j >= 0 && j < NR) m_act[j] = m_pend[j];
    if (bus.chipselect && bus.write && bus.address < 5'd30) m_pend[bus.address] = bus.writedata;
    if (!busy && m_req) begin
      m_armed = 1;
      m_req   = 0;
    end else if (bus.chipselect && bus.write && bus.address == 5'd30 && !was_armed) begin
      m_req = 1;
    end
    if (was_armed && vb) begin
      m_armed  = 0;
      m_copy_e = cyc;
    end
    if (vb) m_fc = m_fc + 16'd1;
  endtask

  task automatic check_model();
    logic [NR*16-1:0] exp_flat;
    for (int k = 0; k < NR; k++) exp_flat[k*16 +: 16] = m_act[k];
    checks++;
    if (ball_regs !== exp_flat) begin
      errors++;
      $display("FAIL model ball_regs cycle %0d: got %h want %h", cyc, ball_regs, exp_flat);
    end
    chk("model commit_done", 32'(commit_done), 32'((cyc - m_copy_e) == 30));
    chk("model frame_count", 32'(frame_count), 32'(m_fc));
    chk("model readdata", 32'(bus.readdata), 32'(m_rd));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (video_on) begin
      if (hcount == 11'(H_TOTAL - 1)) begin
        hcount = 11'd0;
        vcount = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount = hcount + 11'd1;
      end
    end else begin
      hcount = 11'd1;
      vcount = 10'd0;
    end
    if (commit_done) cd_count++;
    check_model();
  endtask

  task automatic op(input bit w, input bit r, input logic [4:0] a, input logic [15:0] d);
    bus.chipselect = w | r;
    bus.write      = w;
    bus.read       = r;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic wait_vb(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (last_vb != cyc && n < FRAME + 10);
    chk({name, " vblank reached"}, 32'(last_vb == cyc), 32'd1);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while (commit_done !== 1'b1 && n < bound);
    chk({name, " commit_done seen"}, 32'(commit_done), 32'd1);
  endtask

  initial begin
    int e, first;
    int fc0, cd0;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = 5'd0; bus.writedata = 16'd0;
    reset = 1'b1; video_on = 0; hcount = 11'd1; vcount = 10'd0;
    cyc = 0; last_vb = -1; cd_count = 0; checks = 0; errors = 0;
    m_copy_e = -100000; m_req = 0; m_armed = 0; m_fc = 16'd0; m_rd = 16'd0;
    tick();
    tick();
    reset = 1'b0;

    // Register-level vectors with video parked (no vblank)
    vecs[0]  = '{1'b0, 1'b1, 5'h00, 16'h0000, 16'd100};
    vecs[1]  = '{1'b0, 1'b1, 5'h1D, 16'h0000, 16'd7};
    vecs[2]  = '{1'b0, 1'b1, 5'h05, 16'h0000, 16'd12};
    vecs[3]  = '{1'b1, 1'b0, 5'h00, 16'd320,  16'd12};
    vecs[4]  = '{1'b0, 1'b1, 5'h00, 16'h0000, 16'd320};
    vecs[5]  = '{1'b0, 1'b1, 5'h1E, 16'h0000, 16'd0};
    vecs[6]  = '{1'b1, 1'b0, 5'h1F, 16'hFFFF, 16'd0};
    vecs[7]  = '{1'b0, 1'b1, 5'h1F, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 5'h1D, 16'h0000, 16'd7};
    vecs[9]  = '{1'b1, 1'b0, 5'h1E, 16'h1234, 16'd7};
    vecs[10] = '{1'b0, 1'b1, 5'h1F, 16'h0000, 16'h0002};
    vecs[11] = '{1'b0, 1'b1, 5'h1F, 16'h0000, 16'h0001};
    vecs[12] = '{1'b1, 1'b0, 5'h1E, 16'h0000, 16'h0001};
    vecs[13] = '{1'b0, 1'b1, 5'h1F, 16'h0000, 16'h0001};
    for (int i = 0; i < 14; i++) begin
      op(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d readdata", i), 32'(bus.readdata), 32'(vecs[i].rd));
    end
    chk("vec active word0 untouched", 32'(word(0)), 32'd100);

    // Armed commit lands on the first vblank
    video_on = 1;
    wait_vb("seq1");
    e = cyc;
    chk("seq1 word0 at E", 32'(word(0)), 32'd100);
    op(1'b0, 1'b1, 5'h1F, 16'd0);
    chk("seq1 busy during copy", 32'(bus.readdata[0]), 32'd1);
    chk("seq1 word0 at E+1", 32'(word(0)), 32'd320);
    wait_done("seq1", 40);
    chk("seq1 done offset", 32'(cyc - e), 32'd30);
    tick();
    chk("seq1 done single", 32'(commit_done), 32'd0);

    // Pending writes without COMMIT never reach the renderer
    op(1'b1, 1'b0, 5'h05, 16'd40);
    fc0 = int'(m_fc);
    cd0 = cd_count;
    repeat (3) wait_vb("seq2");
    chk("seq2 word5 held", 32'(word(5)), 32'd12);
    chk("seq2 frame_count", 32'(frame_count), 32'(fc0 + 3));
    chk("seq2 no commit_done", 32'(cd_count), 32'(cd0));

    // Writes during the copy: ahead of idx are included, behind idx wait
    op(1'b1, 1'b0, 5'h1E, 16'd0);
    wait_vb("seq3");
    e = cyc;
    repeat (10) tick();
    op(1'b1, 1'b0, 5'h03, 16'd7);
    op(1'b1, 1'b0, 5'h14, 16'd99);
    wait_done("seq3", 40);
    chk("seq3 done offset", 32'(cyc - e), 32'd30);
    chk("seq3 word20 new", 32'(word(20)), 32'd99);
    chk("seq3 word3 old", 32'(word(3)), 32'd200);
    chk("seq3 word5 committed", 32'(word(5)), 32'd40);
    op(1'b1, 1'b0, 5'h1E, 16'd0);
    wait_vb("seq3b");
    repeat (35) tick();
    chk("seq3 word3 next commit", 32'(word(3)), 32'd7);

    // COMMIT during COPY re-arms for the following frame
    op(1'b1, 1'b0, 5'h1E, 16'd0);
    wait_vb("seq4");
    e = cyc;
    repeat (3) tick();
    op(1'b1, 1'b0, 5'h1E, 16'd0);
    op(1'b0, 1'b1, 5'h1F, 16'd0);
    chk("seq4 status busy+req", 32'(bus.readdata[1:0]), 32'd3);
    wait_done("seq4a", 40);
    first = cyc;
    chk("seq4 first done offset", 32'(first - e), 32'd30);
    wait_done("seq4b", FRAME + 40);
    chk("seq4 second done one frame later", 32'(cyc - first), 32'(FRAME));

    // Reset in the middle of a copy
    op(1'b1, 1'b0, 5'h00, 16'd555);
    op(1'b1, 1'b0, 5'h1E, 16'd0);
    wait_vb("seq5");
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < NR; k++) chk($sformatf("seq5 default word%0d", k), 32'(word(k)), 32'(dflt[k]));
    cd0 = cd_count;
    op(1'b0, 1'b1, 5'h1F, 16'd0);
    chk("seq5 status after reset", 32'(bus.readdata), 32'd0);
    repeat (FRAME + 40) tick();
    chk("seq5 no commit_done", 32'(cd_count), 32'(cd0));
    chk("seq5 frame_count", 32'(frame_count), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int unsigned p;
      p = $urandom_range(99);
      if (p < 20)      op(1'b1, 1'b0, 5'($urandom_range(31)), 16'($urandom));
      else if (p < 23) op(1'b1, 1'b0, 5'h1E, 16'($urandom));
      else if (p < 33) op(1'b0, 1'b1, 5'($urandom_range(31)), 16'd0);
      else             tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_frame_sync.md
# ball_frame_sync

Double-buffered register controller between the Avalon slave port and the ball renderer. Software writes ball x/y/size values into a pending bank and then writes COMMIT. The block waits for the start of vertical blanking, copies the pending bank into the active bank one word per cycle, and signals completion. The renderer reads only the active bank, so ball geometry never changes mid-frame.

## Interface
- `NUM_BALLS`, 10: number of balls; 3 words each (x, y, size).
- `DW`, 16: register word width.
- `VACTIVE`, 480: first non-visible line; vblank starts at `vcount == VACTIVE`.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `chipselect` in 1: Avalon select.
- `write` in 1: Avalon write strobe.
- `read` in 1: Avalon read strobe.
- `address` in 5: word address.
- `writedata` in DW: write data.
- `readdata` out DW: registered read data.
- `hcount` in 11: from `vga_counters`.
- `vcount` in 10: from `vga_counters`.
- `ball_regs` out NUM_BALLS*3*DW: active bank, flat; word i at bits [i*DW +: DW]; word order x1,y1,size1,x2,…
- `commit_done` out 1: one-cycle pulse when a copy completes.
- `frame_count` out 16: count of vblank starts, wraps.

## Operation
- Addresses 0x00–0x1D: pending words 0–29, read/write. Writes take effect at the next edge.
- 0x1E COMMIT: write of any data sets `commit_req`. Reads return 0.
- 0x1F STATUS: read-only; bit0 = busy (ARMED, COPY or DONE), bit1 = `commit_req`, bits[15:8] = `frame_count[7:0]`. Writes are ignored.
- Reset: both banks load the default table, ball n = (x, y, size):
  - 1 (100,50,10), 2 (200,100,12), 3 (300,150,8), 4 (400,200,14), 5 (500,250,6)
  - 6 (600,300,16), 7 (700,350,9), 8 (800,400,11), 9 (150,75,13), 10 (250,125,7)
- Other reset values: FSM IDLE, `commit_req`=0, `frame_count`=0, `readdata`=0, `commit_done`=0.
- `vb_start` = (`hcount`==0 && `vcount`==VACTIVE); it is true for exactly one cycle per frame.
- FSM states:
  - IDLE: goes to ARMED when `commit_req`=1; `commit_req` clears on that transition.
  - ARMED: goes to COPY on `vb_start`, with `idx`=0.
  - COPY: each cycle, active[idx] <= pending[idx]; `idx`++. After `idx`=29 goes to DONE.
  - DONE: `commit_done`=1 for this one cycle, then IDLE.
- COMMIT while ARMED: no additional effect; `commit_req` stays 0.
- COMMIT while COPY or DONE: sets `commit_req`. The FSM re-arms from IDLE and copies at the next frame.
- Pending write during COPY:
  - To an index not yet copied: the new value is included in this commit.
  - To an index already copied: the new value waits for the next commit.
  - To the same index in the same cycle as its copy: active receives the old pending value; pending receives the new value.
- `frame_count` increments on every `vb_start`, regardless of FSM state; it wraps 0xFFFF→0.
- A synchronous `reset` in any state overrides everything: banks return to defaults, FSM goes to IDLE, no `commit_done`.

## Timing
- `readdata` is valid the cycle after `chipselect`&&`read` (1-cycle latency). It holds its value otherwise.
- Let edge E be the first edge on which `vb_start`=1 while ARMED. FSM enters COPY at E.
- Active word k updates at edge E+1+k, for k = 0..29.
- DONE is entered at E+30; `commit_done` is high during the cycle after E+30.
- FSM is back in IDLE at E+31.
- The whole copy takes 31 cycles, inside the vblank: 45 lines × 1600 cycles.
- COMMIT write at edge W while IDLE: `commit_req`=1 after W, ARMED after W+1. If `vb_start` occurs in the cycle between W and W+1, the commit waits one full frame.

## Structure
- Package `ball_pkg` holds:
  - `NUM_BALLS`, `REGS_PER_BALL`=3, `NUM_REGS`=30.
  - `ADDR_COMMIT`=5'h1E, `ADDR_STATUS`=5'h1F.
  - The default table as a `localparam` array.
  - The FSM state enum: IDLE, ARMED, COPY, DONE.
- One sub-module, `ball_reg_bank`: 30×DW register array with a write port, a combinational read port, a reset-to-default input, and a flat output. Instantiated twice, pending and active.
- The FSM, the `frame_count` counter and the Avalon decode live in the top module.

## Test plan
- Reset, then read 0x00 and 0x1D → `readdata` = 100 and 7; `ball_regs` word 0 = 100; STATUS = 0.
- Write 0x00 = 320, then COMMIT at `vcount`=100 → `ball_regs` word 0 stays 100 until E+1, then 320; `commit_done` pulses once, at E+31; STATUS bit0 = 1 until then.
- No COMMIT, write 0x05 = 40 → active word 5 stays 12 across 3 frames; `frame_count` = 3.
- During COPY at `idx`=10, write 0x03 = 7 and 0x14 = 9 → active word 20 = 9, word 3 unchanged; a second COMMIT at the next frame makes word 3 = 7.
- COMMIT during COPY → STATUS bit1 = 1; a second `commit_done` follows exactly one frame (1600×525 cycles) after the first.
- Assert `reset` at `idx`=15 → all active words return to defaults, FSM IDLE, no `commit_done`.
